// File: rtl/cc_seq_rank.sv
// cc_seq_rank: serial-input score ranker.
// Loads N_STU scores under in_valid, optionally applies a linear transform,
// stably ranks the students with an odd-even transposition sort, counts how
// many are at or above the class average, then streams ranked IDs one per cycle.
module cc_seq_rank #(
    parameter int N_STU = 7,
    parameter int SW    = 4,
    parameter int IDW   = $clog2(N_STU)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [SW-1:0]  in_score,
    input  logic [2:0]     in_opt,
    input  logic [1:0]     in_a,
    input  logic [2:0]     in_b,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    output logic [IDW:0]   out_pass
);

    localparam int VW   = SW + 4;
    localparam int SUMW = VW + IDW;

    localparam logic [IDW-1:0]         LAST_IDX = IDW'(N_STU - 1);
    localparam logic [IDW:0]           OUT_END  = (IDW + 1)'(N_STU);
    localparam logic signed [SUMW-1:0] N_DIV    = SUMW'(N_STU);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SORT,
        S_COUNT,
        S_OUT
    } state_t;

    state_t                 state;
    logic [2:0]             opt_q;
    logic [1:0]             a_q;
    logic [2:0]             b_q;
    logic signed [VW-1:0]   val_q [N_STU];
    logic [IDW-1:0]         id_q  [N_STU];
    logic [IDW-1:0]         load_cnt;
    logic [IDW-1:0]         sort_cnt;
    logic [IDW:0]           out_cnt;
    logic signed [SUMW-1:0] sum_q;
    logic signed [SUMW-1:0] avg_q;
    logic [IDW:0]           pass_q;

    logic signed [VW-1:0]   cap_v;
    logic signed [SUMW-1:0] cap_ext;
    logic signed [VW-1:0]   nxt_val [N_STU];
    logic [IDW-1:0]         nxt_id  [N_STU];
    logic [IDW:0]           pass_cnt;

    // Extend a raw score per the signedness bit, then optionally apply
    // v = score*(a+1) + b; VW bits leave enough headroom that nothing wraps.
    function automatic logic signed [VW-1:0] xform(
        input logic [SW-1:0] s,
        input logic [2:0]    opt,
        input logic [1:0]    a,
        input logic [2:0]    b
    );
        logic signed [VW-1:0] ext;
        logic signed [VW-1:0] gain;
        logic signed [VW-1:0] offs;
        logic signed [VW-1:0] prod;
        ext  = opt[0] ? $signed({{4{s[SW-1]}}, s}) : $signed({4'b0000, s});
        gain = $signed({{(VW-2){1'b0}}, a}) + $signed(VW'(1));
        offs = $signed({{(VW-3){1'b0}}, b});
        prod = ext * gain;
        return opt[2] ? (prod + offs) : ext;
    endfunction

    // Value of the score being captured this cycle; the first score of a frame
    // uses the live mode inputs because they are only registered on that cycle.
    always_comb begin
        cap_v   = (state == S_IDLE) ? xform(in_score, in_opt, in_a, in_b)
                                    : xform(in_score, opt_q, a_q, b_q);
        cap_ext = SUMW'(cap_v);
    end

    // One odd-even transposition pass; ties are broken by lower ID first
    // so the ordering is stable in both directions.
    always_comb begin
        nxt_val = val_q;
        nxt_id  = id_q;
        for (int i = 0; i < N_STU - 1; i++) begin
            if ((i % 2) == int'(sort_cnt[0])) begin
                if ((opt_q[1] ? (val_q[i] < val_q[i+1]) : (val_q[i] > val_q[i+1])) ||
                    ((val_q[i] == val_q[i+1]) && (id_q[i] > id_q[i+1]))) begin
                    nxt_val[i]   = val_q[i+1];
                    nxt_val[i+1] = val_q[i];
                    nxt_id[i]    = id_q[i+1];
                    nxt_id[i+1]  = id_q[i];
                end
            end
        end
    end

    // Number of students whose value is at or above the class average.
    always_comb begin
        pass_cnt = '0;
        for (int i = 0; i < N_STU; i++) begin
            if (SUMW'(val_q[i]) >= avg_q) begin
                pass_cnt = pass_cnt + (IDW + 1)'(1);
            end
        end
    end

    // Frame control FSM: capture, sort, count, then stream registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            opt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            load_cnt  <= '0;
            sort_cnt  <= '0;
            out_cnt   <= '0;
            sum_q     <= '0;
            avg_q     <= '0;
            pass_q    <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_pass  <= '0;
            for (int k = 0; k < N_STU; k++) begin
                val_q[k] <= '0;
                id_q[k]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        opt_q    <= in_opt;
                        a_q      <= in_a;
                        b_q      <= in_b;
                        val_q[0] <= cap_v;
                        sum_q    <= cap_ext;
                        load_cnt <= IDW'(1);
                        for (int k = 0; k < N_STU; k++) begin
                            id_q[k] <= IDW'(k);
                        end
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!in_valid) begin
                        state <= S_IDLE;
                    end else begin
                        val_q[load_cnt] <= cap_v;
                        sum_q           <= sum_q + cap_ext;
                        if (load_cnt == LAST_IDX) begin
                            sort_cnt <= '0;
                            state    <= S_SORT;
                        end else begin
                            load_cnt <= load_cnt + IDW'(1);
                        end
                    end
                end
                S_SORT: begin
                    val_q <= nxt_val;
                    id_q  <= nxt_id;
                    avg_q <= sum_q / N_DIV;
                    if (sort_cnt == LAST_IDX) begin
                        state <= S_COUNT;
                    end else begin
                        sort_cnt <= sort_cnt + IDW'(1);
                    end
                end
                S_COUNT: begin
                    pass_q  <= pass_cnt;
                    out_cnt <= '0;
                    state   <= S_OUT;
                end
                S_OUT: begin
                    if (out_cnt == OUT_END) begin
                        out_valid <= 1'b0;
                        out_id    <= '0;
                        out_pass  <= '0;
                        state     <= S_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        out_id    <= id_q[out_cnt[IDW-1:0]];
                        out_pass  <= pass_q;
                        out_cnt   <= out_cnt + (IDW + 1)'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
